// File: rtl/ejector_route_if.sv
// Address/direction bundle between the ejection stage and whatever feeds it.
interface ejector_route_if #(
  parameter int COORD_W = 3
);
  logic [2*COORD_W-1:0] addr;
  logic [4:0]           direct;

  modport master (output addr, input direct);
  modport slave  (input addr, output direct);
endinterface

// File: rtl/ejector_route.sv
// Dimension-ordered (X then Y) route decision for one mesh node, with a
// one-cycle registered one-hot direction output.
module ejector_route #(
  parameter int COORD_W = 3,
  parameter int LOCAL_X = 4,
  parameter int LOCAL_Y = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ejector_route_if.slave  rif
);
  localparam int ADDR_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] LX = LOCAL_X[COORD_W-1:0];
  localparam logic [COORD_W-1:0] LY = LOCAL_Y[COORD_W-1:0];

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } coord_t;

  typedef struct packed {
    logic x_gt;
    logic x_lt;
    logic y_gt;
    logic y_lt;
  } cmp_t;

  typedef enum logic [4:0] {
    DIR_NONE  = 5'b00000,
    DIR_WEST  = 5'b00001,
    DIR_EAST  = 5'b00010,
    DIR_SOUTH = 5'b00100,
    DIR_NORTH = 5'b01000,
    DIR_LOCAL = 5'b10000
  } dir_e;

  coord_t dst;
  cmp_t   cmp;
  dir_e   direct_d, direct_q;

  assign dst = coord_t'(rif.addr[ADDR_W-1:0]);

  always_comb begin
    cmp      = '0;
    cmp.x_gt = dst.x > LX;
    cmp.x_lt = dst.x < LX;
    cmp.y_gt = dst.y > LY;
    cmp.y_lt = dst.y < LY;
  end

  // X resolves fully before Y is considered; equality on both ejects.
  always_comb begin
    direct_d = DIR_LOCAL;
    if      (cmp.x_gt) direct_d = DIR_EAST;
    else if (cmp.x_lt) direct_d = DIR_WEST;
    else if (cmp.y_gt) direct_d = DIR_NORTH;
    else if (cmp.y_lt) direct_d = DIR_SOUTH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) direct_q <= DIR_NONE;
    else        direct_q <= direct_d;
  end

  assign rif.direct = direct_q;
endmodule

// File: tb/tb_ejector_route.sv
// Directed + exhaustive bench for ejector_route at (4,4) and at the (0,7) edge node.
module tb_ejector_route;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] exp_a_q[$];
  logic [4:0] exp_b_q[$];

  always #5 clk = ~clk;

  ejector_route_if #(.COORD_W(3)) ifa ();
  ejector_route_if #(.COORD_W(3)) ifb ();

  ejector_route #(.COORD_W(3), .LOCAL_X(4), .LOCAL_Y(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rif(ifa.slave));
  ejector_route #(.COORD_W(3), .LOCAL_X(0), .LOCAL_Y(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .rif(ifb.slave));

  function automatic logic [4:0] route(input logic [5:0] a, input int lx, input int ly);
    int dx, dy;
    dx = int'(a[2:0]);
    dy = int'(a[5:3]);
    if (dx > lx) return 5'b00010;
    if (dx < lx) return 5'b00001;
    if (dy > ly) return 5'b01000;
    if (dy < ly) return 5'b00100;
    return 5'b10000;
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic check_onehot(input string tag, input logic [4:0] got);
    checks++;
    assert ($onehot(got)) else begin
      errors++;
      $error("FAIL %s not one-hot got %b exp one-hot", tag, got);
    end
  endtask

  task automatic drive(input logic [5:0] a);
    ifa.addr = a;
    ifb.addr = a;
    exp_a_q.push_back(rst_n ? route(a, 4, 4) : 5'b00000);
    exp_b_q.push_back(rst_n ? route(a, 0, 7) : 5'b00000);
  endtask

  task automatic settle(input string tag, input bit both);
    logic [4:0] ea, eb;
    @(posedge clk);
    #1;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    check({tag, "_a"}, ifa.direct, ea);
    if (both) check({tag, "_b"}, ifb.direct, eb);
  endtask

  task automatic step(input logic [5:0] a, input string tag);
    drive(a);
    settle(tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.addr = 6'b100101;
    ifb.addr = 6'b100101;

    step(6'b100101, "rst0");
    step(6'b100101, "rst1");
    rst_n = 1'b1;
    step(6'b100101, "rst_rel");

    step(6'b100101, "east");
    step(6'b100001, "west");
    step(6'b110100, "north");
    step(6'b000100, "south");
    step(6'b100100, "local");
    step(6'b111000, "xpri_west");
    step(6'b000111, "xpri_east");

    // Latency: new address just after the edge must not show until the next edge.
    step(6'b100100, "lat_pre");
    drive(6'b100101);
    #3;
    check("lat_hold", ifa.direct, 5'b10000);
    settle("lat_post", 1'b0);

    // Mid-stream reset for a single edge.
    step(6'b110100, "mid_north");
    rst_n = 1'b0;
    step(6'b110100, "mid_rst");
    rst_n = 1'b1;
    step(6'b110100, "mid_resume");

    for (int i = 0; i < 64; i++) begin
      drive(6'(i));
      settle($sformatf("sweep%0d", i), 1'b1);
      check_onehot($sformatf("oh_a%0d", i), ifa.direct);
      check_onehot($sformatf("oh_b%0d", i), ifb.direct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
